// File: rtl/inst_prefetch_queue_if.sv
// Fetch front-end bus bundle: redirect, imem request/response, core inst port.
// master = prefetch queue, slave = core/memory side.
interface inst_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;

  modport master (
    input  redirect, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output inst_valid, inst_pc, inst,
    input  inst_ready
  );

  modport slave (
    output redirect, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  inst_valid, inst_pc, inst,
    output inst_ready
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher with credit-limited imem requests and a
// PC-tagged FIFO. IFQ_BYPASS_EN: empty-queue response bypass to the core.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   rst,
  inst_prefetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] prd_q, prd_d;
  logic [AW-1:0] pwr_q, pwr_d;
  logic [31:0]   fdata_q [DEPTH];
  logic [31:0]   fdata_d [DEPTH];
  logic [31:0]   fpc_q   [DEPTH];
  logic [31:0]   fpc_d   [DEPTH];
  logic [31:0]   ppc_q   [DEPTH];
  logic [31:0]   ppc_d   [DEPTH];

  logic [CW-1:0] occ;
  logic [CW-1:0] live;
  logic [CW:0]   used;
  logic          empty;
  logic          full;
  logic          resp;
  logic          dropping;
  logic          req_fire;
  logic          enq;
  logic          deq;
  logic          byp_take;
  logic [AW-1:0] head;
  logic [AW-1:0] wr_idx;
  logic          unused_ok;

  assign unused_ok = ^bus.redirect_pc[1:0];

  assign occ   = wr_ptr_q - rd_ptr_q;
  assign live  = inflight_q - drop_q;
  assign used  = {1'b0, occ} + {1'b0, live};
  assign empty = (occ == '0);
  assign full  = (occ == DEPTH_C);
  assign head  = rd_ptr_q[AW-1:0];
  assign wr_idx = wr_ptr_q[AW-1:0];

  // Credit: every live request is guaranteed a FIFO slot on return.
  assign bus.imem_req_valid = !rst && !bus.redirect && (used < DEPTH_W);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

  assign resp     = bus.imem_resp_valid;
  assign dropping = resp && (drop_q != '0);

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp = !rst && !bus.redirect && empty && resp && (drop_q == '0);
  assign bus.inst_valid = !rst && (!empty || byp);
  assign bus.inst_pc    = empty ? ppc_q[prd_q] : fpc_q[head];
  assign bus.inst       = empty ? bus.imem_resp_data : fdata_q[head];
  assign byp_take       = byp && bus.inst_ready;
`else
  assign bus.inst_valid = !rst && !empty;
  assign bus.inst_pc    = fpc_q[head];
  assign bus.inst       = fdata_q[head];
  assign byp_take       = 1'b0;
`endif

  assign enq = resp && (drop_q == '0) && !bus.redirect && !byp_take;
  assign deq = !rst && !bus.redirect && !empty && bus.inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp);
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q + CW'(deq);
    wr_ptr_d   = wr_ptr_q + CW'(enq);
    prd_d      = prd_q + AW'(resp);
    pwr_d      = pwr_q + AW'(req_fire);
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (dropping) begin
      drop_d = drop_q - 1'b1;
    end
    // No request fires on a redirect, so this is the post-cycle inflight.
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      drop_d     = inflight_q - CW'(resp);
      rd_ptr_d   = wr_ptr_q;
    end
  end

  always_comb begin
    fdata_d = fdata_q;
    fpc_d   = fpc_q;
    ppc_d   = ppc_q;
    if (enq) begin
      fdata_d[wr_idx] = bus.imem_resp_data;
      fpc_d[wr_idx]   = ppc_q[prd_q];
    end
    if (req_fire) begin
      ppc_d[pwr_q] = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      prd_q      <= '0;
      pwr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fdata_q[i] <= '0;
        fpc_q[i]   <= '0;
        ppc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      prd_q      <= prd_d;
      pwr_q      <= pwr_d;
      fdata_q    <= fdata_d;
      fpc_q      <= fpc_d;
      ppc_q      <= ppc_d;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(resp && (drop_q == '0) && !bus.redirect && full)
  );

endmodule
